// File: rtl/imem_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words, writes them
// to instruction RAM from address 0 and holds the core in reset until done.
module imem_loader #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic [ADDR_W:0]   word_count,
  input  logic              load_abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wd,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        dbg_state
);

  // Handshake: a byte moves on a rising edge where byte_valid && byte_ready;
  // byte_valid may be held or dropped freely, byte_ready depends only on state.

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FLUSH = 2'd2, RUN = 2'd3} state_t;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       part_q, part_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wd_q, wd_d;
  logic              ready_q, cpu_reset_q, busy_q, done_q;
  logic              xfer, legal_cnt;

  assign xfer      = byte_valid && ready_q;
  assign legal_cnt = (word_count != '0) && (word_count <= DEPTH_W);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    part_d  = part_q;
    err_d   = err_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE, RUN: begin
        if (load_req) begin
          if (legal_cnt) begin
            count_d = word_count;
            err_d   = 1'b0;
            idx_d   = '0;
            lane_d  = '0;
            part_d  = '0;
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (load_abort) begin
          // Abort beats a coincident 4th byte: the half-built word is dropped.
          state_d = IDLE;
          err_d   = 1'b1;
          lane_d  = '0;
          part_d  = '0;
        end else if (xfer) begin
          if (lane_q == 2'd3) begin
            we_d    = 1'b1;
            waddr_d = idx_q[ADDR_W-1:0];
            wd_d    = {byte_data, part_q};
            idx_d   = idx_q + ONE_W;
            lane_d  = '0;
            if (idx_q == count_q - ONE_W) state_d = FLUSH;
          end else begin
            part_d[{lane_q, 3'b000} +: 8] = byte_data;
            lane_d = lane_q + 2'd1;
          end
        end
      end
      FLUSH: begin
        if (load_abort) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      idx_q       <= '0;
      lane_q      <= '0;
      part_q      <= '0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wd_q        <= '0;
      ready_q     <= 1'b0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      lane_q      <= lane_d;
      part_q      <= part_d;
      err_q       <= err_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wd_q        <= wd_d;
      ready_q     <= (state_d == LOAD);
      cpu_reset_q <= (state_d != RUN);
      busy_q      <= (state_d == LOAD) || (state_d == FLUSH);
      done_q      <= (state_q == FLUSH) && (state_d == RUN);
    end
  end

  assign byte_ready = ready_q;
  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wd    = wd_q;
  assign cpu_reset  = cpu_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign dbg_state  = state_q;

endmodule
